// File: rtl/alu_issue_unit.sv
// Two-entry issue pipeline in front of a 3-bit-control ALU: decode into E, capture result into R.
// Define ALU_ISSUE_TRACE_EN to print a simulation trace line on every E advance.
module alu_issue_unit #(
   parameter int D_WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               req_valid,
   output logic               req_ready,
   input  logic [1:0]         req_class,
   input  logic [2:0]         req_funct3,
   input  logic               req_funct7b5,
   input  logic [D_WIDTH-1:0] req_rs1,
   input  logic [D_WIDTH-1:0] req_rs2,
   input  logic [D_WIDTH-1:0] req_imm,
   input  logic [4:0]         req_rd,
   output logic [2:0]         ALUctrl,
   output logic [D_WIDTH-1:0] ALUop1,
   output logic [D_WIDTH-1:0] ALUop2,
   input  logic [D_WIDTH-1:0] ALUout,
   input  logic               EQ,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [D_WIDTH-1:0] rsp_result,
   output logic [4:0]         rsp_rd,
   output logic               rsp_taken,
   output logic               rsp_illegal,
   output logic [15:0]        retired_cnt
);

   typedef enum logic [1:0] {
      KIND_ALU = 2'd0,
      KIND_BEQ = 2'd1,
      KIND_BNE = 2'd2,
      KIND_ILL = 2'd3
   } kind_t;

   localparam logic [2:0] CTRL_ADD  = 3'b000;
   localparam logic [2:0] CTRL_SUB  = 3'b001;
   localparam logic [2:0] CTRL_AND  = 3'b010;
   localparam logic [2:0] CTRL_OR   = 3'b011;
   localparam logic [2:0] CTRL_SLTU = 3'b100;

   logic               e_valid_reg;
   logic [2:0]         e_ctrl_reg;
   logic [D_WIDTH-1:0] e_op1_reg;
   logic [D_WIDTH-1:0] e_op2_reg;
   logic [4:0]         e_rd_reg;
   kind_t              e_kind_reg;

   logic               r_valid_reg;
   logic [D_WIDTH-1:0] r_result_reg;
   logic [4:0]         r_rd_reg;
   logic               r_taken_reg;
   logic               r_illegal_reg;
   logic [15:0]        retired_reg;

   logic               e_adv;
   logic               accept;
   logic               rsp_fire;

   logic [2:0]         dec_ctrl;
   logic [D_WIDTH-1:0] dec_op1;
   logic [D_WIDTH-1:0] dec_op2;
   kind_t              dec_kind;

   logic [D_WIDTH-1:0] r_result_next;
   logic               r_taken_next;

   assign e_adv     = e_valid_reg && (!r_valid_reg || rsp_ready);
   assign req_ready = !e_valid_reg || e_adv;
   assign accept    = req_valid && req_ready;
   assign rsp_fire  = r_valid_reg && rsp_ready;

   // Illegal operations keep the add code and zero operands so the ALU sees a harmless op.
   always_comb begin
      dec_ctrl = CTRL_ADD;
      dec_kind = KIND_ILL;
      dec_op1  = '0;
      dec_op2  = '0;
      case (req_class)
         2'b00, 2'b01: begin
            case (req_funct3)
               3'b000: begin
                  dec_kind = KIND_ALU;
                  dec_ctrl = (req_class == 2'b00 && req_funct7b5) ? CTRL_SUB : CTRL_ADD;
               end
               3'b111: begin
                  dec_kind = KIND_ALU;
                  dec_ctrl = CTRL_AND;
               end
               3'b110: begin
                  dec_kind = KIND_ALU;
                  dec_ctrl = CTRL_OR;
               end
               3'b011: begin
                  dec_kind = KIND_ALU;
                  dec_ctrl = CTRL_SLTU;
               end
               default: ;
            endcase
            if (dec_kind == KIND_ALU) begin
               dec_op1 = req_rs1;
               dec_op2 = (req_class == 2'b01) ? req_imm : req_rs2;
            end
         end
         2'b10: begin
            if (req_funct3 == 3'b000 || req_funct3 == 3'b001) begin
               dec_kind = (req_funct3 == 3'b000) ? KIND_BEQ : KIND_BNE;
               dec_ctrl = CTRL_SUB;
               dec_op1  = req_rs1;
               dec_op2  = req_rs2;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         e_valid_reg <= 1'b0;
         e_ctrl_reg  <= '0;
         e_op1_reg   <= '0;
         e_op2_reg   <= '0;
         e_rd_reg    <= '0;
         e_kind_reg  <= KIND_ALU;
      end else if (accept) begin
         e_valid_reg <= 1'b1;
         e_ctrl_reg  <= dec_ctrl;
         e_op1_reg   <= dec_op1;
         e_op2_reg   <= dec_op2;
         e_rd_reg    <= req_rd;
         e_kind_reg  <= dec_kind;
      end else if (e_adv) begin
         e_valid_reg <= 1'b0;
      end
   end

   assign ALUctrl = e_valid_reg ? e_ctrl_reg : 3'b000;
   assign ALUop1  = e_valid_reg ? e_op1_reg  : '0;
   assign ALUop2  = e_valid_reg ? e_op2_reg  : '0;

   always_comb begin
      r_result_next = '0;
      r_taken_next  = 1'b0;
      case (e_kind_reg)
         KIND_ALU: r_result_next = ALUout;
         KIND_BEQ: r_taken_next  = EQ;
         KIND_BNE: r_taken_next  = !EQ;
         default:  ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid_reg   <= 1'b0;
         r_result_reg  <= '0;
         r_rd_reg      <= '0;
         r_taken_reg   <= 1'b0;
         r_illegal_reg <= 1'b0;
      end else if (e_adv) begin
         r_valid_reg   <= 1'b1;
         r_result_reg  <= r_result_next;
         r_rd_reg      <= e_rd_reg;
         r_taken_reg   <= r_taken_next;
         r_illegal_reg <= (e_kind_reg == KIND_ILL);
      end else if (rsp_fire) begin
         r_valid_reg   <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         retired_reg <= '0;
      end else if (rsp_fire) begin
         retired_reg <= retired_reg + 16'd1;
      end
   end

   assign rsp_valid   = r_valid_reg;
   assign rsp_result  = r_result_reg;
   assign rsp_rd      = r_rd_reg;
   assign rsp_taken   = r_taken_reg;
   assign rsp_illegal = r_illegal_reg;
   assign retired_cnt = retired_reg;

`ifdef ALU_ISSUE_TRACE_EN
   always_ff @(posedge clk) begin
      if (rst_n && e_adv) begin
         $display("alu_issue: rd=%0d ctrl=%03b op1=%h op2=%h out=%h eq=%b",
                  e_rd_reg, ALUctrl, ALUop1, ALUop2, ALUout, EQ);
      end
   end
`endif

endmodule

// File: tb/tb_alu_issue_unit.sv
// Scoreboard bench for alu_issue_unit: a behavioural ALU closes the loop, expected responses queue on acceptance.
module tb_alu_issue_unit;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [1:0]    req_class;
   logic [2:0]    req_funct3;
   logic          req_funct7b5;
   logic [W-1:0]  req_rs1;
   logic [W-1:0]  req_rs2;
   logic [W-1:0]  req_imm;
   logic [4:0]    req_rd;
   logic [2:0]    ALUctrl;
   logic [W-1:0]  ALUop1;
   logic [W-1:0]  ALUop2;
   logic [W-1:0]  ALUout;
   logic          EQ;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_result;
   logic [4:0]    rsp_rd;
   logic          rsp_taken;
   logic          rsp_illegal;
   logic [15:0]   retired_cnt;

   typedef struct {
      logic [W-1:0] result;
      logic [4:0]   rd;
      logic         taken;
      logic         illegal;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   failures = 0;
   int   cyc = 0;
   int   run_len = 0;
   int   last_pop_cyc = -10;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   alu_issue_unit #(.D_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_class(req_class), .req_funct3(req_funct3), .req_funct7b5(req_funct7b5),
      .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm), .req_rd(req_rd),
      .ALUctrl(ALUctrl), .ALUop1(ALUop1), .ALUop2(ALUop2), .ALUout(ALUout), .EQ(EQ),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_rd(rsp_rd), .rsp_taken(rsp_taken), .rsp_illegal(rsp_illegal),
      .retired_cnt(retired_cnt)
   );

   // Behavioural ALU attached to the unit.
   always_comb begin
      ALUout = '0;
      case (ALUctrl)
         3'b000: ALUout = ALUop1 + ALUop2;
         3'b001: ALUout = ALUop1 - ALUop2;
         3'b010: ALUout = ALUop1 & ALUop2;
         3'b011: ALUout = ALUop1 | ALUop2;
         3'b100: ALUout = {{(W-1){1'b0}}, ALUop1 < ALUop2};
         default: ALUout = '0;
      endcase
   end
   assign EQ = (ALUop1 == ALUop2);

   function automatic exp_t expect_of(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                                      input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic [W-1:0] imm, input logic [4:0] rd);
      exp_t r;
      logic [W-1:0] o2;
      r.result = '0; r.rd = rd; r.taken = 1'b0; r.illegal = 1'b0;
      o2 = (cls == 2'b01) ? imm : b;
      if (cls == 2'b00 || cls == 2'b01) begin
         case (f3)
            3'b000: r.result = (cls == 2'b00 && f7) ? a - o2 : a + o2;
            3'b111: r.result = a & o2;
            3'b110: r.result = a | o2;
            3'b011: r.result = (a < o2) ? 1 : 0;
            default: r.illegal = 1'b1;
         endcase
      end else if (cls == 2'b10) begin
         if (f3 == 3'b000) r.taken = (a == b);
         else if (f3 == 3'b001) r.taken = (a != b);
         else r.illegal = 1'b1;
      end else begin
         r.illegal = 1'b1;
      end
      return r;
   endfunction

   // Scoreboard monitor: pop on response handshake, push on request handshake.
   always @(negedge clk) begin
      if (!rst_n) begin
         sb.delete();
      end else begin
         if (rsp_valid && rsp_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL rsp_unexpected: got result=%h rd=%0d with empty scoreboard", rsp_result, rsp_rd);
            end else begin
               mon_e = sb.pop_front();
               if ({rsp_result, rsp_rd, rsp_taken, rsp_illegal} !==
                   {mon_e.result, mon_e.rd, mon_e.taken, mon_e.illegal}) begin
                  failures++;
                  $display("FAIL rsp_data: got result=%h rd=%0d taken=%b illegal=%b, need result=%h rd=%0d taken=%b illegal=%b",
                           rsp_result, rsp_rd, rsp_taken, rsp_illegal,
                           mon_e.result, mon_e.rd, mon_e.taken, mon_e.illegal);
               end else begin
                  $display("rsp rd=%0d result=%h taken=%b illegal=%b ok", rsp_rd, rsp_result, rsp_taken, rsp_illegal);
               end
            end
            run_len = (last_pop_cyc == cyc - 1) ? run_len + 1 : 1;
            last_pop_cyc = cyc;
         end
         if (req_valid && req_ready)
            sb.push_back(expect_of(req_class, req_funct3, req_funct7b5, req_rs1, req_rs2, req_imm, req_rd));
      end
   end

   task automatic send(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] imm, input logic [4:0] rd);
      bit acc;
      int n;
      req_class = cls; req_funct3 = f3; req_funct7b5 = f7;
      req_rs1 = a; req_rs2 = b; req_imm = imm; req_rd = rd;
      req_valid = 1'b1;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 100) begin
         @(negedge clk);
         acc = req_ready;
         @(posedge clk);
         #1;
         n++;
      end
      req_valid = 1'b0;
      checks++;
      if (!acc) begin
         failures++;
         $display("FAIL send_timeout: rd=%0d req_ready=%b after %0d cycles, need 1", rd, req_ready, n);
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sb.size() != 0 || rsp_valid) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL drain_timeout: pending=%0d rsp_valid=%b, need 0/0", sb.size(), rsp_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({rsp_valid, rsp_result, rsp_rd, rsp_taken, rsp_illegal} !== '0) begin
         failures++;
         $display("FAIL reset_rsp: valid=%b result=%h rd=%0d taken=%b illegal=%b, need all 0",
                  rsp_valid, rsp_result, rsp_rd, rsp_taken, rsp_illegal);
      end
      checks++;
      if ({ALUctrl, ALUop1, ALUop2} !== '0) begin
         failures++;
         $display("FAIL reset_alu: ctrl=%b op1=%h op2=%h, need 0", ALUctrl, ALUop1, ALUop2);
      end
      checks++;
      if (req_ready !== 1'b1 || retired_cnt !== 16'd0) begin
         failures++;
         $display("FAIL reset_ready: req_ready=%b retired=%0d, need 1/0", req_ready, retired_cnt);
      end
      $display("test_reset done");
      @(posedge clk);
      #1;
   endtask

   task automatic test_alu_ops();
      rsp_ready = 1'b1;
      send(2'b00, 3'b000, 1'b0, 32'd5, 32'd7, 32'd0, 5'd3);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || ALUctrl !== 3'b000 || ALUop1 !== 32'd5 || ALUop2 !== 32'd7) begin
         failures++;
         $display("FAIL add_e_stage: rsp_valid=%b ctrl=%b op1=%h op2=%h, need 0/000/5/7",
                  rsp_valid, ALUctrl, ALUop1, ALUop2);
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd12 || rsp_rd !== 5'd3 || rsp_illegal !== 1'b0) begin
         failures++;
         $display("FAIL add_latency: valid=%b result=%h rd=%0d illegal=%b, need 1/0000000c/3/0",
                  rsp_valid, rsp_result, rsp_rd, rsp_illegal);
      end
      @(posedge clk);
      #1;
      send(2'b00, 3'b000, 1'b1, 32'd5, 32'd7, 32'd0, 5'd4);
      send(2'b01, 3'b011, 1'b0, 32'd1, 32'd0, 32'hFFFF_FFFF, 5'd5);
      send(2'b10, 3'b000, 1'b0, 32'd9, 32'd9, 32'd0, 5'd6);
      send(2'b10, 3'b001, 1'b0, 32'd9, 32'd9, 32'd0, 5'd7);
      send(2'b01, 3'b110, 1'b1, 32'h1200_0000, 32'd0, 32'h0000_0034, 5'd8);
      drain();
      $display("test_alu_ops done");
   endtask

   task automatic test_back_to_back();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      send(2'b00, 3'b000, 1'b0, 32'd1, 32'd2, 32'd0, 5'd10);
      send(2'b00, 3'b011, 1'b0, 32'd3, 32'd2, 32'd0, 5'd11);
      send(2'b01, 3'b111, 1'b0, 32'hFFFF_0000, 32'd0, 32'h0F0F_0F0F, 5'd12);
      send(2'b00, 3'b000, 1'b1, 32'd0, 32'd1, 32'd0, 5'd13);
      drain();
      checks++;
      if (run_len !== 4) begin
         failures++;
         $display("FAIL b2b_consecutive: run=%0d, need 4", run_len);
      end
      checks++;
      if (retired_cnt !== 16'd4) begin
         failures++;
         $display("FAIL b2b_retired: retired=%0d, need 4", retired_cnt);
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_backpressure();
      rsp_ready = 1'b0;
      send(2'b00, 3'b000, 1'b0, 32'd100, 32'd23, 32'd0, 5'd1);
      send(2'b01, 3'b110, 1'b0, 32'h0000_00F0, 32'd0, 32'h0000_000F, 5'd2);
      req_class = 2'b00; req_funct3 = 3'b111; req_funct7b5 = 1'b0;
      req_rs1 = 32'h0000_00FF; req_rs2 = 32'h0000_003C; req_imm = '0; req_rd = 5'd4;
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_result !== 32'd123 || rsp_rd !== 5'd1) begin
            failures++;
            $display("FAIL full_hold: req_ready=%b valid=%b result=%h rd=%0d, need 0/1/0000007b/1",
                     req_ready, rsp_valid, rsp_result, rsp_rd);
         end
         checks++;
         if (ALUctrl !== 3'b011 || ALUop1 !== 32'h0000_00F0 || ALUop2 !== 32'h0000_000F) begin
            failures++;
            $display("FAIL full_alu: ctrl=%b op1=%h op2=%h, need 011/000000f0/0000000f", ALUctrl, ALUop1, ALUop2);
         end
         @(posedge clk);
         #1;
      end
      checks++;
      if (sb.size() !== 2) begin
         failures++;
         $display("FAIL full_accepted: accepted=%0d, need 2", sb.size());
      end
      rsp_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b1) begin
         failures++;
         $display("FAIL release_ready: req_ready=%b, need 1", req_ready);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      drain();
      $display("test_backpressure done");
   endtask

   task automatic test_illegal();
      rsp_ready = 1'b1;
      send(2'b11, 3'b000, 1'b0, 32'h0000_DEAD, 32'h0000_BEEF, 32'h1, 5'd7);
      @(negedge clk);
      checks++;
      if (ALUctrl !== 3'b000 || ALUop1 !== 32'd0 || ALUop2 !== 32'd0) begin
         failures++;
         $display("FAIL illegal_operands: ctrl=%b op1=%h op2=%h, need 0", ALUctrl, ALUop1, ALUop2);
      end
      @(posedge clk);
      #1;
      send(2'b00, 3'b001, 1'b0, 32'd5, 32'd5, 32'd0, 5'd8);
      send(2'b10, 3'b100, 1'b0, 32'd5, 32'd6, 32'd0, 5'd9);
      send(2'b01, 3'b010, 1'b0, 32'd5, 32'd0, 32'd3, 5'd6);
      drain();
      $display("test_illegal done");
   endtask

   task automatic test_reset_midflight();
      rsp_ready = 1'b0;
      send(2'b00, 3'b000, 1'b0, 32'd1, 32'd1, 32'd0, 5'd1);
      send(2'b00, 3'b110, 1'b0, 32'd6, 32'd9, 32'd0, 5'd2);
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0) begin
         failures++;
         $display("FAIL midreset_full: valid=%b req_ready=%b, need 1/0", rsp_valid, req_ready);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || retired_cnt !== 16'd0 || req_ready !== 1'b1 || rsp_result !== 32'd0) begin
         failures++;
         $display("FAIL midreset_clear: valid=%b retired=%0d req_ready=%b result=%h, need 0/0/1/0",
                  rsp_valid, retired_cnt, req_ready, rsp_result);
      end
      checks++;
      if ({ALUctrl, ALUop1, ALUop2} !== '0) begin
         failures++;
         $display("FAIL midreset_alu: ctrl=%b op1=%h op2=%h, need 0", ALUctrl, ALUop1, ALUop2);
      end
      @(posedge clk);
      #1;
      rsp_ready = 1'b1;
      $display("test_reset_midflight done");
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
      req_class = '0; req_funct3 = '0; req_funct7b5 = 1'b0;
      req_rs1 = '0; req_rs2 = '0; req_imm = '0; req_rd = '0;
      test_reset();
      test_alu_ops();
      test_back_to_back();
      test_backpressure();
      test_illegal();
      test_reset_midflight();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/alu_issue_unit.md
# alu_issue_unit

Sequencing front end for the 3-bit-control ALU: accepts decoded RV32 integer/branch operations over a valid/ready request channel and maps funct3/funct7 to the ALU control code. It registers the operands, drives the ALU, and captures the result and equality flag into a response register. A valid/ready response channel returns the result, branch outcome and destination tag. It sits between decode and writeback as a two-entry pipeline with full backpressure.

## Interface
- D_WIDTH, 32, datapath width; also the width of the ALU operands and result.
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts the request this cycle.
- req_class  in  2  00 R-type ALU, 01 I-type ALU, 10 branch, 11 illegal.
- req_funct3  in  3  instruction funct3.
- req_funct7b5  in  1  instruction bit 30; selects sub for R-type funct3 000.
- req_rs1  in  D_WIDTH  operand 1.
- req_rs2  in  D_WIDTH  operand 2; used for R-type and branch.
- req_imm  in  D_WIDTH  sign-extended immediate; used for I-type.
- req_rd  in  5  destination tag; passed through unchanged.
- ALUctrl  out  3  to ALU: 000 add, 001 sub, 010 and, 011 or, 100 unsigned less-than.
- ALUop1, ALUop2  out  D_WIDTH  to ALU operands.
- ALUout  in  D_WIDTH  ALU result, combinational from ALUctrl/ALUop1/ALUop2.
- EQ  in  1  ALU equality flag.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_result  out  D_WIDTH  ALU result; 0 for branch and illegal operations.
- rsp_rd  out  5  tag of the response.
- rsp_taken  out  1  branch taken; 0 for non-branch operations.
- rsp_illegal  out  1  unsupported operation.
- retired_cnt  out  16  count of responses consumed; wraps from 0xFFFF to 0.

## Operation

Decode is applied at request acceptance and the result is stored in the E register.
- ALU classes (R-type and I-type):
  - funct3 000: add (000); sub (001) only when R-type and funct7b5 is 1.
  - funct3 111: and (010).
  - funct3 110: or (011).
  - funct3 011: unsigned less-than (100).
  - Other funct3 values: illegal.
- ALU operands: op2 = rs2 for R-type, imm for I-type.
- Branch class: funct3 000 (beq) and 001 (bne) use sub, with op2 = rs2. Other funct3 values are illegal.
- Class 11: illegal.
- Illegal operations: stored with ALUctrl 000 and zero operands. The response carries rsp_illegal=1, rsp_result=0 and rsp_taken=0.

Pipeline stages:
- **E stage:** single entry (e_valid). While e_valid=1, ALUctrl/ALUop1/ALUop2 are driven directly from the E registers. While e_valid=0, all three are driven to 0.
- **R stage:** single entry (r_valid).
  - When E advances, R captures ALUout into rsp_result (forced to 0 for branch/illegal).
  - rsp_taken = EQ for beq, !EQ for bne, 0 otherwise.
- Advance and acceptance conditions:
  - e_adv = e_valid && (!r_valid || rsp_ready).
  - req_ready = !e_valid || e_adv. This is combinational from rsp_ready; there is no combinational path from req_valid to req_ready.
- retired_cnt increments on each rsp_valid && rsp_ready cycle.

## Timing
- Latency: request accepted at edge N, ALU driven during cycle N+1, rsp_valid high after edge N+1. That is 2 cycles, with throughput of one operation per cycle.
- Full condition: e_valid=1, r_valid=1 and rsp_ready=0 force req_ready=0. Both entries hold stable, and the ALU ports do not change.
- Simultaneous events:
  - Response consumed and E advancing in the same cycle: R reloads with no bubble.
  - Request accepted while E advances: E reloads with no bubble.
- Backpressure: response outputs hold stable while rsp_valid=1 and rsp_ready=0.
- Reset (also when asserted mid-operation): on an edge with rst_n=0, e_valid, r_valid and retired_cnt clear to 0, and all E/R data registers clear to 0. In-flight operations are discarded.
- Reset output values: rsp_valid=0, rsp_result=0, rsp_rd=0, rsp_taken=0, rsp_illegal=0, ALUctrl=000, ALUop1=ALUop2=0, req_ready=1.

## Configuration
- ALU_ISSUE_TRACE_EN defined: on every E advance, a simulation-only $display prints rd, ALUctrl, ALUop1, ALUop2, ALUout and EQ.
- ALU_ISSUE_TRACE_EN undefined: no display statements; behaviour is otherwise identical.

## Test plan
- Reset then idle -> all outputs at their reset values; req_ready=1.
- R-type add, rs1=5, rs2=7, rd=3 -> two cycles later rsp_result=12, rsp_rd=3, rsp_illegal=0; sub with funct7b5=1 -> 0xFFFFFFFE.
- I-type sltu, rs1=1, imm=0xFFFFFFFF -> rsp_result=1. Then beq rs1=rs2=9 -> rsp_taken=1, rsp_result=0. Then bne with the same operands -> rsp_taken=0.
- Back-to-back stream of 4 ops with rsp_ready=1 -> 4 responses on consecutive cycles; retired_cnt=4.
- Hold rsp_ready=0 with 3 requests offered -> 2 accepted, req_ready=0 and outputs stable. Release -> responses arrive in order, then the third request is accepted.
- Class 11 or R-type funct3 001 -> rsp_illegal=1, result 0. Assert rst_n=0 while both stages are full -> rsp_valid=0 next cycle and retired_cnt=0.
